// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage pipeline sequencer for the 5-stage MIPS core.
// Generates PC / IF/ID / ID/EX / EX/MEM enables from load-use hazards,
// decoder flush requests and data-memory readiness, with a memory watchdog
// and saturating stall/flush counters for performance debug.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_RUN        | normal flow; hazards and flush requests evaluated
// S_LOAD_STALL | one cycle after a load-use bubble; load_use not re-checked
// S_MEM_WAIT   | pipeline frozen waiting on data memory; wait_cnt running
// S_ERROR      | memory watchdog expired; frozen until rst
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [1:0]       flush_req,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_ERROR      = 2'd3
  } state_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_uses_rt;
  logic w_load_use;
  logic w_mem_stall;

  // Hazard detection: only R-type, beq, bne and sw read rt as a source.
  always_comb begin
    w_uses_rt   = id_opcode inside {6'b000000, 6'b000100, 6'b000101, 6'b101011};
    w_load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (w_uses_rt && (ex_rt == id_rt)));
    w_mem_stall = mem_access && !mem_ready;
  end

  // Next-state and enable generation; reset forces a bubble and holds the PC.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_hold    = 1'b0;
    mem_error      = 1'b0;
    if (rst) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      id_ex_bubble   = 1'b1;
      w_state_nxt    = S_RUN;
      w_wait_cnt_nxt = 8'd0;
    end else begin
      case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (w_mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            if (r_state == S_RUN) begin
              w_state_nxt    = S_MEM_WAIT;
              w_wait_cnt_nxt = 8'd1;
            end else if (r_wait_cnt == TIMEOUT) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
          end else if (w_load_use) begin
            // Branch operands are stale here, so any flush request is dropped;
            // the decoder repeats it in the following cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            w_state_nxt  = S_LOAD_STALL;
          end else begin
            if_id_flush = (flush_req != 2'b00);
            w_state_nxt = S_RUN;
          end
        end
        S_LOAD_STALL: begin
          if (w_mem_stall) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            ex_mem_hold    = 1'b1;
            w_state_nxt    = S_MEM_WAIT;
            w_wait_cnt_nxt = 8'd1;
          end else begin
            if_id_flush = (flush_req != 2'b00);
            w_state_nxt = S_RUN;
          end
        end
        S_ERROR: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
          mem_error   = 1'b1;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  // State and watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Saturating performance counters; reset cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (if_id_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: two instances (default parameters and a
// short-timeout / narrow-counter build) share stimulus; a reference model
// pushes expected outputs per cycle and a monitor compares them.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read;
  logic [1:0] flush_req;
  logic       mem_access, mem_ready;

  logic        a_pc, a_ifw, a_fl, a_bub, a_hold, a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifw, b_fl, b_bub, b_hold, b_err;
  logic [2:0]  b_stall, b_flush;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush_req(flush_req),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl),
    .id_ex_bubble(a_bub), .ex_mem_hold(a_hold), .mem_error(a_err),
    .stall_cycles(a_stall), .flush_count(a_flush));

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush_req(flush_req),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl),
    .id_ex_bubble(b_bub), .ex_mem_hold(b_hold), .mem_error(b_err),
    .stall_cycles(b_stall), .flush_count(b_flush));

  typedef struct packed {
    logic        pc;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        hold;
    logic        err;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, indexed by instance: 0 = dut_a, 1 = dut_b.
  int tmo[2] = '{16, 4};
  int cmax[2] = '{65535, 7};
  int consec_stall[2];
  bit dead[2];
  bit after_bubble[2];
  int stalls[2];
  int flushes[2];

  task automatic model_step(input int k, output exp_t e);
    bit ms, lu, reads_rt;
    e = '0;
    e.stall = 16'(stalls[k]);
    e.flush = 16'(flushes[k]);
    if (rst) begin
      e.bub = 1'b1;
      consec_stall[k] = 0; dead[k] = 0; after_bubble[k] = 0;
      stalls[k] = 0; flushes[k] = 0;
      return;
    end
    ms = mem_access && !mem_ready;
    reads_rt = (id_opcode == 6'd0) || (id_opcode == 6'd4) ||
               (id_opcode == 6'd5) || (id_opcode == 6'd43);
    lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (reads_rt && ex_rt == id_rt));
    e.pc = 1; e.ifw = 1;
    if (dead[k]) begin
      e.pc = 0; e.ifw = 0; e.hold = 1; e.err = 1;
    end else if (ms) begin
      e.pc = 0; e.ifw = 0; e.hold = 1;
      consec_stall[k]++;
      after_bubble[k] = 0;
      if (consec_stall[k] > tmo[k]) dead[k] = 1;
    end else begin
      consec_stall[k] = 0;
      if (lu && !after_bubble[k]) begin
        e.pc = 0; e.ifw = 0; e.bub = 1;
        after_bubble[k] = 1;
      end else begin
        after_bubble[k] = 0;
        e.fl = (flush_req != 0);
      end
    end
    if (!e.pc && stalls[k] < cmax[k]) stalls[k]++;
    if (e.fl && flushes[k] < cmax[k]) flushes[k]++;
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic emr, input logic [4:0] ert,
                     input logic [1:0] fr, input logic ma, input logic mr);
    exp_t ea, eb;
    @(posedge clk); #1;
    rst = r; id_opcode = op; id_rs = rs; id_rt = rt; ex_mem_read = emr;
    ex_rt = ert; flush_req = fr; mem_access = ma; mem_ready = mr;
    model_step(0, ea);
    model_step(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a.pc_write", 16'(a_pc), 16'(e.pc));
        chk("a.if_id_write", 16'(a_ifw), 16'(e.ifw));
        chk("a.if_id_flush", 16'(a_fl), 16'(e.fl));
        chk("a.id_ex_bubble", 16'(a_bub), 16'(e.bub));
        chk("a.ex_mem_hold", 16'(a_hold), 16'(e.hold));
        chk("a.mem_error", 16'(a_err), 16'(e.err));
        chk("a.stall_cycles", a_stall, e.stall);
        chk("a.flush_count", a_flush, e.flush);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b.pc_write", 16'(b_pc), 16'(e.pc));
        chk("b.if_id_write", 16'(b_ifw), 16'(e.ifw));
        chk("b.if_id_flush", 16'(b_fl), 16'(e.fl));
        chk("b.id_ex_bubble", 16'(b_bub), 16'(e.bub));
        chk("b.ex_mem_hold", 16'(b_hold), 16'(e.hold));
        chk("b.mem_error", 16'(b_err), 16'(e.err));
        chk("b.stall_cycles", 16'(b_stall), e.stall);
        chk("b.flush_count", 16'(b_flush), e.flush);
      end
    end
  end

  logic [5:0] ops[7] = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd63, 6'd8};
  logic [4:0] regs[4] = '{5'd0, 5'd5, 5'd7, 5'd3};

  initial begin
    int hang;
    int budget;
    logic mr;
    rst = 1; id_opcode = 6'd63; id_rs = 0; id_rt = 0; ex_mem_read = 0;
    ex_rt = 0; flush_req = 0; mem_access = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    // Reset state, then load-use on rs (second cycle is the post-bubble cycle).
    cyc(1, 6'd0, 5, 1, 1, 5, 0, 0, 0);
    cyc(0, 6'd0, 5, 1, 1, 5, 0, 0, 0);
    cyc(0, 6'd0, 5, 1, 1, 5, 0, 0, 0);
    cyc(0, 6'd63, 0, 0, 0, 0, 0, 0, 0);
    // No false hazard: ex_rt=0 and lw in ID matching only on rt.
    cyc(0, 6'd0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 6'd35, 1, 7, 1, 7, 0, 0, 0);
    // Branch flush alone, then coincident with load_use.
    cyc(0, 6'd4, 1, 2, 0, 0, 2'b01, 0, 0);
    cyc(0, 6'd4, 5, 2, 1, 5, 2'b01, 0, 0);
    cyc(0, 6'd4, 5, 2, 1, 5, 2'b01, 0, 0);
    cyc(0, 6'd63, 0, 0, 0, 0, 2'b11, 0, 0);
    // Memory wait of three cycles with a hazard present, then release.
    repeat (3) cyc(0, 6'd0, 5, 0, 1, 5, 0, 1, 0);
    cyc(0, 6'd0, 5, 0, 1, 5, 0, 1, 1);
    cyc(0, 6'd63, 0, 0, 0, 0, 0, 0, 1);
    // Watchdog: long stall, ready returns late, then one-cycle reset.
    repeat (20) cyc(0, 6'd63, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 6'd63, 0, 0, 0, 0, 2'b01, 1, 1);
    cyc(1, 6'd63, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 6'd63, 0, 0, 0, 0, 0, 0, 0);
    // Counter saturation on the narrow instance.
    repeat (10) cyc(0, 6'd63, 0, 0, 0, 0, 2'b10, 0, 0);
    // Randomised traffic with occasional memory hangs and resets.
    hang = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hang == 0 && $urandom_range(0, 99) < 3) hang = $urandom_range(3, 22);
      if (hang > 0) begin
        hang--;
        mr = 0;
      end else begin
        mr = ($urandom_range(0, 2) != 0);
      end
      cyc(($urandom_range(0, 79) == 0),
          ops[$urandom_range(0, 6)], regs[$urandom_range(0, 3)],
          regs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
          regs[$urandom_range(0, 3)],
          ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
          (hang > 0) ? 1'b1 : 1'($urandom_range(0, 1)), mr);
    end
    budget = 10;
    while ((q_a.size() > 0 || q_b.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline sequencing block for the 5-stage MIPS core. It sits beside the ID-stage instruction decoder and drives the PC, IF/ID, ID/EX and EX/MEM register enables.
- Detects load-use hazards and applies the decoder's branch/jump flush request.
- Freezes the pipeline while data memory is not ready, with a watchdog timeout.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERROR (range 2..255)
CNT_W, 16, width of the stall_cycles and flush_count counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_opcode  in  6  opcode of the instruction in ID
id_rs  in  5  rs field in ID
id_rt  in  5  rt field in ID
ex_mem_read  in  1  instruction in EX is a load (memorySignals[1] of the ID/EX register)
ex_rt  in  5  destination rt of the instruction in EX
flush_req  in  2  decoder flush request: 00 none, 01 branch taken, 10 jump, 11 treated as 01
mem_access  in  1  MEM stage holds a valid load or store
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  clear IF/ID to nop (opcode 111111)
id_ex_bubble  out  1  load zeros into ID/EX control fields
ex_mem_hold  out  1  hold EX/MEM and MEM/WB
mem_error  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0 (rst excluded)
flush_count  out  CNT_W  saturating count of cycles with if_id_flush=1

Behaviour:
- State is a 2-bit register: RUN, LOAD_STALL, MEM_WAIT, ERROR. There is also an 8-bit wait_cnt.
- Outputs are combinational from state and inputs. Counters and state are registered.
- During rst:
  - state and counters are 0, and next state is RUN.
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, ex_mem_hold=0, mem_error=0.
- uses_rt is 1 for opcode 000000, 000100, 000101, 101011, and 0 otherwise (including lw 100011 and nop 111111).
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
- mem_stall = mem_access && !mem_ready.
- Default outputs: pc_write=1, if_id_write=1, all others 0.
- RUN, conditions checked in priority order:
  1. mem_stall: freeze. pc_write=0, if_id_write=0, ex_mem_hold=1, no bubble. Next state MEM_WAIT, wait_cnt<=1.
  2. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. Next state LOAD_STALL. flush_req is ignored this cycle because the branch operands are stale; the decoder re-requests next cycle.
  3. flush_req!=0: if_id_flush=1, pc_write=1. Next state RUN.
  4. Otherwise: defaults.
- LOAD_STALL (exactly one cycle):
  - load_use is not evaluated.
  - If mem_stall: freeze as in RUN rule 1 and go to MEM_WAIT.
  - Otherwise apply flush rule 3 or the defaults, then go to RUN.
- MEM_WAIT:
  - While mem_stall: freeze and wait_cnt++.
  - If wait_cnt==MEM_TIMEOUT and still stalled: next state ERROR.
  - On the first cycle with !mem_stall: evaluate exactly as RUN (rules 2–4) and take RUN's next state. A back-to-back new stall cannot occur in the same cycle.
- ERROR: permanent freeze (pc_write=0, if_id_write=0, ex_mem_hold=1) and mem_error=1. All inputs are ignored; exit only via rst.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_write=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-ERROR takes effect on the next edge with no residual state.
- Simultaneous load_use and mem_stall: the freeze wins and no bubble is inserted. load_use is re-evaluated when the pipeline releases.

Test Plan:
1. Load-use on rs: ex_mem_read=1, ex_rt=5, id_opcode=000000, id_rs=5 → one cycle with pc_write=0 and id_ex_bubble=1, next cycle pc_write=1; stall_cycles=1.
2. No false hazard: ex_rt=0 matching id_rs=0, and lw in ID with id_rt==ex_rt=7 → pc_write stays 1 and no bubble.
3. Branch flush: flush_req=01 for 1 cycle in RUN → if_id_flush=1, pc_write=1, flush_count=1. The same request coincident with load_use → no flush that cycle; the flush occurs in LOAD_STALL when re-requested.
4. Memory wait: mem_access=1, mem_ready=0 for 3 cycles then 1 → ex_mem_hold=1 for 3 cycles, release on the 4th, no bubble; stall_cycles=3.
5. Timeout: MEM_TIMEOUT=4 with mem_ready held 0 → ERROR entered after wait_cnt reaches 4; mem_error=1 persists with mem_ready later 1; rst=1 for one cycle clears everything.
6. Saturation: CNT_W=3 with 10 flush cycles → flush_count stops at 7.
